// File: rtl/timebase_pkg.sv
// Purpose: shared types and the 1-2-5 factor rule for the acquisition timebase controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package timebase_pkg;

    localparam int DEF_SEL_W    = 4;
    localparam int DEF_LEN_W    = 16;
    localparam int DEF_FACTOR_W = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // 1-2-5 sequence: mantissa cycles 1,2,5 and each group of three is one decade up.
    function automatic logic [DEF_FACTOR_W-1:0] factor_125(input int unsigned sel);
        logic [DEF_FACTOR_W-1:0] f;
        case (sel % 3)
            0:       f = DEF_FACTOR_W'(1);
            1:       f = DEF_FACTOR_W'(2);
            default: f = DEF_FACTOR_W'(5);
        endcase
        for (int i = 0; i < 12; i++) begin
            if (i < int'(sel / 3)) begin
                f = f * DEF_FACTOR_W'(10);
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/timebase_lut.sv
// Purpose: maps a timebase select to the scaler's scaling factor (1-2-5 table).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the select immediately.
module timebase_lut
    import timebase_pkg::*;
#(
    parameter int SEL_W    = DEF_SEL_W,
    parameter int FACTOR_W = DEF_FACTOR_W
) (
    input  logic [SEL_W-1:0]    sel_i,
    output logic [FACTOR_W-1:0] factor_o
);

    // Explicit table for the standard 16 settings; wider selects fall back to the rule.
    always_comb begin
        factor_o = FACTOR_W'(factor_125(32'(sel_i)));
        case (32'(sel_i))
            0:  factor_o = FACTOR_W'(1);
            1:  factor_o = FACTOR_W'(2);
            2:  factor_o = FACTOR_W'(5);
            3:  factor_o = FACTOR_W'(10);
            4:  factor_o = FACTOR_W'(20);
            5:  factor_o = FACTOR_W'(50);
            6:  factor_o = FACTOR_W'(100);
            7:  factor_o = FACTOR_W'(200);
            8:  factor_o = FACTOR_W'(500);
            9:  factor_o = FACTOR_W'(1000);
            10: factor_o = FACTOR_W'(2000);
            11: factor_o = FACTOR_W'(5000);
            12: factor_o = FACTOR_W'(10000);
            13: factor_o = FACTOR_W'(20000);
            14: factor_o = FACTOR_W'(50000);
            15: factor_o = FACTOR_W'(100000);
            default: ;
        endcase
    end

endmodule

// File: rtl/acq_timebase_ctrl.sv
// Purpose: sequences the acquisition clock scaler (factor, run flag) and turns scaled edges into sample strobes.
// Latency: run_flag rises HOLDOFF_CYCLES+1 cycles after arm; strobe is one cycle after a scaled_clock rise.
// Backpressure: none; arm while busy is dropped, stop aborts immediately.
module acq_timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int SEL_W          = DEF_SEL_W,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int FACTOR_W       = DEF_FACTOR_W,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic [SEL_W-1:0]    timebase_sel,
    input  logic                mode,
    input  logic                arm,
    input  logic                stop,
    input  logic [LEN_W-1:0]    record_length,
    input  logic                scaled_clock,
    output logic [FACTOR_W-1:0] scaling_factor,
    output logic                run_flag,
    output logic                sample_strobe,
    output logic [LEN_W-1:0]    sample_index,
    output logic                busy,
    output logic                done
);

    localparam int               HOLD_W    = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FACTOR_W-1:0] factor_q, factor_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic                strobe_q, strobe_d;
    logic                scaled_q;
    logic [FACTOR_W-1:0] lut_factor;
    logic                arm_ok;
    logic                last_sample;

    timebase_lut #(
        .SEL_W    (SEL_W),
        .FACTOR_W (FACTOR_W)
    ) u_lut (
        .sel_i    (timebase_sel),
        .factor_o (lut_factor)
    );

    assign arm_ok      = arm && !(mode && (record_length == '0));
    assign last_sample = (idx_q == len_q - LEN_W'(1));

    // Next-state: reset handled in the register; here stop > arm > timebase change > strobe/complete.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        factor_d = factor_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        len_d    = len_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop && state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end else if (arm_ok) begin
                    state_d  = ST_LOAD;
                    hold_d   = '0;
                    factor_d = lut_factor;
                    sel_d    = timebase_sel;
                    mode_d   = mode;
                    len_d    = record_length;
                    idx_d    = '0;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!mode_q && (timebase_sel != sel_q)) begin
                    // Factor only changes together with run_flag dropping.
                    state_d  = ST_LOAD;
                    hold_d   = '0;
                    factor_d = lut_factor;
                    sel_d    = timebase_sel;
                    idx_d    = '0;
                end else if (strobe_q) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (mode_q && last_sample) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A strobe is only emitted if the controller stays in RUN across this edge.
        strobe_d = (state_q == ST_RUN) && (state_d == ST_RUN) && scaled_clock && !scaled_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            factor_q <= FACTOR_W'(factor_125(0));
            sel_q    <= '0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            scaled_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            factor_q <= factor_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            scaled_q <= scaled_clock;
        end
    end

    assign scaling_factor = factor_q;
    assign run_flag       = (state_q == ST_RUN);
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign sample_strobe  = strobe_q;
    assign sample_index   = idx_q;

endmodule

// File: tb/tb_acq_timebase_ctrl.sv
// Purpose: self-checking bench for acq_timebase_ctrl driving a behavioural clock scaler.
// Latency: cycle numbers are counted from the cycle in which arm is presented (cycle 0).
// Backpressure: n/a.
module tb_acq_timebase_ctrl;

    // Narrow index so the wrap boundary is reachable in a short run.
    localparam int TB_LEN_W = 8;
    localparam int TB_FW    = 30;

    logic                clock_in = 1'b0;
    logic                reset_in = 1'b1;
    logic [3:0]          timebase_sel = '0;
    logic                mode = 1'b0;
    logic                arm = 1'b0;
    logic                stop = 1'b0;
    logic [TB_LEN_W-1:0] record_length = '0;
    logic                scaled_clock;
    logic [TB_FW-1:0]    scaling_factor;
    logic                run_flag;
    logic                sample_strobe;
    logic [TB_LEN_W-1:0] sample_index;
    logic                busy;
    logic                done;

    logic [TB_FW-1:0]    scal_cnt;
    int                  cyc = 0;
    int                  n_checks = 0;
    int                  n_fail = 0;
    int                  exp_cyc[$];
    int                  exp_idx[$];

    acq_timebase_ctrl #(
        .SEL_W          (4),
        .LEN_W          (TB_LEN_W),
        .FACTOR_W       (TB_FW),
        .HOLDOFF_CYCLES (2)
    ) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .timebase_sel   (timebase_sel),
        .mode           (mode),
        .arm            (arm),
        .stop           (stop),
        .record_length  (record_length),
        .scaled_clock   (scaled_clock),
        .scaling_factor (scaling_factor),
        .run_flag       (run_flag),
        .sample_strobe  (sample_strobe),
        .sample_index   (sample_index),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    // Behavioural scaler: output toggles every `factor` enabled cycles, held at 0 while disabled.
    always @(posedge clock_in) begin
        if (run_flag !== 1'b1) begin
            scal_cnt     <= '0;
            scaled_clock <= 1'b0;
        end else if (scal_cnt == scaling_factor - TB_FW'(1)) begin
            scal_cnt     <= '0;
            scaled_clock <= ~scaled_clock;
        end else begin
            scal_cnt <= scal_cnt + TB_FW'(1);
        end
    end

    // Scoreboard: every strobe the DUT emits must match the oldest expected (cycle, index).
    always begin
        int ec;
        int ei;
        @(posedge clock_in);
        #1;
        if (sample_strobe === 1'b1) begin
            n_checks++;
            if (exp_cyc.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: strobe at cycle %0d idx %0d, none required", cyc, sample_index);
            end else begin
                ec = exp_cyc.pop_front();
                ei = exp_idx.pop_front();
                if (cyc !== ec || sample_index !== TB_LEN_W'(ei)) begin
                    n_fail++;
                    $display("FAIL strobe: got cycle %0d idx %0d, required cycle %0d idx %0d",
                             cyc, sample_index, ec, ei);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        reset_in = 1'b0;
        n_checks++; if (run_flag !== 1'b0) begin n_fail++; $display("FAIL reset_run_flag: got %b want 0", run_flag); end
        n_checks++; if (scaling_factor !== TB_FW'(1)) begin n_fail++; $display("FAIL reset_factor: got %0d want 1", scaling_factor); end
        n_checks++; if (sample_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
        n_checks++; if (sample_index !== '0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", sample_index); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        tick();
    endtask

    task automatic test_single_shot();
        int t0;
        logic exp_run;
        t0 = cyc;
        timebase_sel = 4'd0; mode = 1'b1; record_length = TB_LEN_W'(4); arm = 1'b1;
        for (int k = 0; k < 4; k++) begin exp_cyc.push_back(t0 + 5 + 2 * k); exp_idx.push_back(k); end
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            exp_run = (c >= 3 && c <= 11);
            n_checks++;
            if (run_flag !== exp_run) begin n_fail++; $display("FAIL ss_run_flag: cycle %0d got %b want %b", c, run_flag, exp_run); end
            if (c == 1) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ss_busy_load: got %b want 1", busy); end
            end
            if (c == 12) begin
                n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ss_done: got %b want 1", done); end
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_busy_done: got %b want 0", busy); end
            end
            tick();
        end
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL ss_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
        // Zero-length single-shot arm in DONE must be ignored.
        record_length = '0; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ss_arm_len0_done: got done %b busy %b want 1 0", done, busy); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ss_stop_done: got %b want 0", done); end
        tick();
    endtask

    task automatic test_continuous_spacing();
        int t0;
        t0 = cyc;
        timebase_sel = 4'd3; mode = 1'b0; arm = 1'b1;
        for (int k = 0; k < 4; k++) begin exp_cyc.push_back(t0 + 14 + 20 * k); exp_idx.push_back(k); end
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 74; c++) begin
            if (c == 2) begin
                n_checks++; if (scaling_factor !== TB_FW'(10)) begin n_fail++; $display("FAIL cont_factor: got %0d want 10", scaling_factor); end
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL cont_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_index_wrap();
        int t0;
        t0 = cyc;
        timebase_sel = 4'd0; mode = 1'b0; arm = 1'b1;
        for (int k = 0; k < 260; k++) begin exp_cyc.push_back(t0 + 5 + 2 * k); exp_idx.push_back(k % 256); end
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 523; c++) begin
            if (c == 515) begin
                n_checks++; if (sample_index !== TB_LEN_W'(255)) begin n_fail++; $display("FAIL wrap_before: got %0d want 255", sample_index); end
            end
            if (c == 516) begin
                n_checks++; if (sample_index !== TB_LEN_W'(0)) begin n_fail++; $display("FAIL wrap_after: got %0d want 0", sample_index); end
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL wrap_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
        tick();
    endtask

    task automatic test_timebase_change();
        int t0;
        t0 = cyc;
        timebase_sel = 4'd0; mode = 1'b0; arm = 1'b1;
        exp_cyc.push_back(t0 + 5);  exp_idx.push_back(0);
        exp_cyc.push_back(t0 + 7);  exp_idx.push_back(1);
        exp_cyc.push_back(t0 + 14); exp_idx.push_back(0);
        exp_cyc.push_back(t0 + 18); exp_idx.push_back(1);
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 9 || c == 10) begin
                n_checks++; if (run_flag !== 1'b0) begin n_fail++; $display("FAIL tbc_holdoff: cycle %0d got %b want 0", c, run_flag); end
            end
            if (c == 9) begin
                n_checks++; if (scaling_factor !== TB_FW'(2)) begin n_fail++; $display("FAIL tbc_factor: got %0d want 2", scaling_factor); end
                n_checks++; if (sample_index !== '0) begin n_fail++; $display("FAIL tbc_index: got %0d want 0", sample_index); end
            end
            if (c == 11) begin
                n_checks++; if (run_flag !== 1'b1) begin n_fail++; $display("FAIL tbc_restart: got %b want 1", run_flag); end
            end
            if (c == 8) timebase_sel = 4'd1;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL tbc_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
        tick();
    endtask

    task automatic test_stop_on_final();
        int t0;
        t0 = cyc;
        timebase_sel = 4'd0; mode = 1'b1; record_length = TB_LEN_W'(2); arm = 1'b1;
        exp_cyc.push_back(t0 + 5); exp_idx.push_back(0);
        exp_cyc.push_back(t0 + 7); exp_idx.push_back(1);
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stopfin_done: got %b want 0", done); end
        n_checks++; if (run_flag !== 1'b0) begin n_fail++; $display("FAIL stopfin_run_flag: got %b want 0", run_flag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stopfin_busy: got %b want 0", busy); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stopfin_done_later: got %b want 0", done); end
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL stopfin_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
        tick();
    endtask

    task automatic test_arm_ignored();
        int t0;
        t0 = cyc;
        timebase_sel = 4'd0; mode = 1'b0; record_length = TB_LEN_W'(3); arm = 1'b1;
        exp_cyc.push_back(t0 + 5); exp_idx.push_back(0);
        exp_cyc.push_back(t0 + 7); exp_idx.push_back(1);
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) begin arm = 1'b1; mode = 1'b1; end
            if (c == 6) begin
                arm = 1'b0;
                n_checks++; if (run_flag !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL armrun_state: got run %b busy %b want 1 1", run_flag, busy); end
            end
            if (c == 8) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL armrun_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
        mode = 1'b1; record_length = '0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (busy !== 1'b0 || run_flag !== 1'b0) begin n_fail++; $display("FAIL arm_len0: got busy %b run %b want 0 0", busy, run_flag); end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        int t0;
        t0 = cyc;
        timebase_sel = 4'd1; mode = 1'b0; arm = 1'b1;
        exp_cyc.push_back(t0 + 6); exp_idx.push_back(0);
        tick();
        arm = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) reset_in = 1'b1;
            tick();
        end
        reset_in = 1'b0;
        n_checks++; if (run_flag !== 1'b0) begin n_fail++; $display("FAIL rst_run_flag: got %b want 0", run_flag); end
        n_checks++; if (scaling_factor !== TB_FW'(1)) begin n_fail++; $display("FAIL rst_factor: got %0d want 1", scaling_factor); end
        n_checks++; if (sample_index !== '0) begin n_fail++; $display("FAIL rst_index: got %0d want 0", sample_index); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || sample_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got busy %b done %b strobe %b want 0 0 0", busy, done, sample_strobe); end
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (scaled_clock !== 1'b0) begin n_fail++; $display("FAIL rst_scaler_idle: got %b want 0", scaled_clock); end
            tick();
        end
        n_checks++; if (exp_cyc.size() != 0) begin n_fail++; $display("FAIL rst_missing_strobes: got %0d left want 0", exp_cyc.size()); exp_cyc.delete(); exp_idx.delete(); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous_spacing();
        test_index_wrap();
        test_timebase_change();
        test_stop_on_final();
        test_arm_ignored();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
